// File: rtl/mode_power_ctrl.sv
// Magnetron duty-cycle controller: latches the cook mode on start and drives the
// magnetron enable with a fixed-period on/off pattern, with door-open pause/resume.
module mode_power_ctrl #(
    parameter int unsigned TICK_DIV     = 100_000_000,
    parameter int unsigned PERIOD_TICKS = 10,
    parameter int unsigned LOW_ON       = 3,
    parameter int unsigned NORM_ON      = 6,
    parameter int unsigned HIGH_ON      = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] mode,
    input  logic       start,
    input  logic       stop,
    input  logic       door_open,
    output logic       magnetron_on,
    output logic       running,
    output logic [1:0] mode_latched,
    output logic       mode_err
);

    localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int PH_W  = (PERIOD_TICKS > 1) ? $clog2(PERIOD_TICKS) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(PERIOD_TICKS - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_PAUSE = 2'd2;

    logic [1:0]       state;
    logic [DIV_W-1:0] div_cnt;
    logic [PH_W-1:0]  phase;
    logic [31:0]      on_ticks;

    // Counters advance on every RUN edge that is not a stop, including the edge
    // that moves into PAUSE; they are only held while actually paused.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            div_cnt      <= '0;
            phase        <= '0;
            mode_latched <= 2'b10;
            mode_err     <= 1'b0;
        end else begin
            mode_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (!stop && start && !door_open) begin
                        if (mode != 2'b00) begin
                            state        <= S_RUN;
                            mode_latched <= mode;
                            div_cnt      <= '0;
                            phase        <= '0;
                        end else begin
                            mode_err <= !mode_err;
                        end
                    end
                end
                S_RUN: begin
                    if (stop) begin
                        state   <= S_IDLE;
                        div_cnt <= '0;
                        phase   <= '0;
                    end else begin
                        if (door_open) begin
                            state <= S_PAUSE;
                        end
                        if (div_cnt == DIV_LAST) begin
                            div_cnt <= '0;
                            phase   <= (phase == PH_LAST) ? '0 : phase + PH_W'(1);
                        end else begin
                            div_cnt <= div_cnt + DIV_W'(1);
                        end
                    end
                end
                S_PAUSE: begin
                    if (stop) begin
                        state   <= S_IDLE;
                        div_cnt <= '0;
                        phase   <= '0;
                    end else if (start && !door_open) begin
                        state <= S_RUN;
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    div_cnt <= '0;
                    phase   <= '0;
                end
            endcase
        end
    end

    always_comb begin
        on_ticks = 32'd0;
        case (mode_latched)
            2'b01:   on_ticks = 32'(LOW_ON);
            2'b10:   on_ticks = 32'(NORM_ON);
            2'b11:   on_ticks = 32'(HIGH_ON);
            default: on_ticks = 32'd0;
        endcase
    end

    assign magnetron_on = (state == S_RUN) && (32'(phase) < on_ticks);
    assign running      = (state != S_IDLE);

endmodule
